// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, functs,
// state numbering, datapath select codes and the decoded instruction class.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] EOP_SIGN = 2'b00;
    localparam logic [1:0] EOP_ZERO = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_SHL2 = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_EXT   = 2'b10;

    // One-hot instruction class; all-zero means unsupported.
    typedef struct packed {
        logic addu;
        logic subu;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
    } instr_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> one-hot class plus
// an illegal flag for anything outside the supported subset.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_t     instr,
    output logic       illegal
);

    always_comb begin
        instr = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instr.addu = 1'b1;
                    FN_SUBU: instr.subu = 1'b1;
                    FN_SLL:  instr.nop  = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  instr.ori = 1'b1;
            OP_LUI:  instr.lui = 1'b1;
            OP_LW:   instr.lw  = 1'b1;
            OP_SW:   instr.sw  = 1'b1;
            OP_BEQ:  instr.beq = 1'b1;
            OP_J:    instr.j   = 1'b1;
            default: ;
        endcase
    end

    assign illegal = (instr == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: registered state, outputs decoded from the
// current state and the instruction held in IR, plus a retired counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSel,
    output logic [1:0]       EOp,
    output logic [2:0]       ALUOp,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       WDSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    instr_t            ins;
    logic              dec_ill;
    logic              r_type;
    logic              held;
    logic              retire;

    mc_decode u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .instr   (ins),
        .illegal (dec_ill)
    );

    assign r_type  = ins.addu | ins.subu | ins.nop;
    assign held    = (st == S_DECODE) || (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
    assign state   = st;
    assign retired = cnt;

    // Every path that returns to FETCH (other than reset) completes an instruction.
    assign retire = ((st == S_DECODE) && ins.j)
                  | ((st == S_EXEC) && (ins.nop | ins.beq))
                  | ((st == S_MEM) && mem_ready && ins.sw)
                  | (st == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_FETCH;
            illegal <= 1'b0;
            cnt     <= '0;
        end else begin
            if (retire)
                cnt <= cnt + CNT_W'(1);
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    if (dec_ill) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end else if (ins.j) begin
                        st <= S_FETCH;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ins.nop || ins.beq)     st <= S_FETCH;
                    else if (ins.lw || ins.sw)  st <= S_MEM;
                    else                        st <= S_WB;
                end
                S_MEM:    if (mem_ready) st <= ins.sw ? S_FETCH : S_WB;
                S_WB:     st <= S_FETCH;
                default:  st <= S_HALT;
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSel    = PC_SEQ;
        EOp      = EOP_SIGN;
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        WDSel    = WD_ALU;

        // Datapath selects stay put from DECODE to WB so the datapath sees no glitches.
        if (held) begin
            RegDst = r_type;
            ALUSrc = ins.ori | ins.lui | ins.lw | ins.sw;
            if (ins.ori)       EOp = EOP_ZERO;
            else if (ins.lui)  EOp = EOP_LUI;
            else if (ins.beq)  EOp = EOP_SHL2;
            if (ins.lw)        WDSel = WD_DM;
            else if (ins.lui)  WDSel = WD_EXT;
        end

        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                if (ins.j) begin
                    PCWrite = 1'b1;
                    PCSel   = PC_JMP;
                end
            end
            S_EXEC: begin
                if (ins.subu || ins.beq) ALUOp = ALU_SUB;
                else if (ins.ori)        ALUOp = ALU_OR;
                if (ins.beq) begin
                    PCWrite = zero;
                    PCSel   = PC_BR;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = ins.sw;
            end
            S_WB:    RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: stimulus queues hand-computed per-cycle
// expectations, a monitor pops and compares them on the falling edge.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, IRWrite, PCWrite, ALUSrc, RegWrite, RegDst, illegal;
    logic [1:0]  PCSel, EOp, WDSel;
    logic [2:0]  ALUOp, state;
    logic [31:0] retired;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSel(PCSel), .EOp(EOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .state(state),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, mw, irw, pcw;
        logic [1:0] pcsel, eop;
        logic [2:0] alu;
        logic       asrc, rw, rd;
        logic [1:0] wd;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(int st, int req, int mw, int irw, int pcw, int pcsel, int eop,
                                int alu, int asrc, int rw, int rd, int wd, int ill, int ret);
        exp_t e;
        e.c.st    = 3'(st);
        e.c.req   = 1'(req);
        e.c.mw    = 1'(mw);
        e.c.irw   = 1'(irw);
        e.c.pcw   = 1'(pcw);
        e.c.pcsel = 2'(pcsel);
        e.c.eop   = 2'(eop);
        e.c.alu   = 3'(alu);
        e.c.asrc  = 1'(asrc);
        e.c.rw    = 1'(rw);
        e.c.rd    = 1'(rd);
        e.c.wd    = 2'(wd);
        e.c.ill   = 1'(ill);
        e.ret     = 32'(ret);
        return e;
    endfunction

    // Drive inputs for one cycle (called at posedge+1) and queue the outputs expected in it.
    task automatic cyc(input logic r, input logic rdy, input logic z, input exp_t e);
        reset     = r;
        mem_ready = rdy;
        zero      = z;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    // Monitor
    initial begin
        exp_t e;
        ctl_t a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = '{state, mem_req, MemWrite, IRWrite, PCWrite, PCSel, EOp, ALUOp,
                      ALUSrc, RegWrite, RegDst, WDSel, illegal};
                vectors++;
                if (a != e.c) begin
                    miscompares++;
                    $display("FAIL ctl vec %0d: got st=%0d req%b mw%b irw%b pcw%b pcsel=%b eop=%b alu=%b asrc%b rw%b rd%b wd=%b ill%b, want %h (got %h)",
                             vectors, a.st, a.req, a.mw, a.irw, a.pcw, a.pcsel, a.eop, a.alu,
                             a.asrc, a.rw, a.rd, a.wd, a.ill, e.c, a);
                end
                if (retired !== e.ret) begin
                    miscompares++;
                    $display("FAIL retired vec %0d: got %h want %h", vectors, retired, e.ret);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // ori after reset
        ins(6'b001101, 6'b000000);
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,0));
        cyc(0, 1, 0, mk(1,0,0,0,0,0,1,0,1,0,0,0,0,0));
        cyc(0, 1, 0, mk(2,0,0,0,0,0,1,2,1,0,0,0,0,0));
        cyc(0, 1, 0, mk(4,0,0,0,0,0,1,0,1,1,0,0,0,0));
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,1));

        // lw with a 3-cycle memory stall
        ins(6'b100011, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,1));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,1,0,0,1,0,1));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,0,0,1,0,0,1,0,1));
        repeat (3) cyc(0, 0, 0, mk(3,1,0,0,0,0,0,0,1,0,0,1,0,1));
        cyc(0, 1, 0, mk(3,1,0,0,0,0,0,0,1,0,0,1,0,1));
        cyc(0, 0, 0, mk(4,0,0,0,0,0,0,0,1,1,0,1,0,1));
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,2));

        // beq taken then not taken
        ins(6'b000100, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,2));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,3,0,0,0,0,0,0,2));
        cyc(0, 0, 1, mk(2,0,0,0,1,1,3,1,0,0,0,0,0,2));
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,3));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,3,0,0,0,0,0,0,3));
        cyc(0, 0, 0, mk(2,0,0,0,0,1,3,1,0,0,0,0,0,3));

        // subu
        ins(6'b000000, 6'b100011);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,4));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0,1,0,0,4));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,0,1,0,0,1,0,0,4));
        cyc(0, 0, 0, mk(4,0,0,0,0,0,0,0,0,1,1,0,0,4));

        // lui
        ins(6'b001111, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,5));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,2,0,1,0,0,2,0,5));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,2,0,1,0,0,2,0,5));
        cyc(0, 0, 0, mk(4,0,0,0,0,0,2,0,1,1,0,2,0,5));

        // nop retires from EXEC
        ins(6'b000000, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,6));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0,1,0,0,6));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,0,0,0,0,1,0,0,6));

        // sw completing normally
        ins(6'b101011, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,7));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,1,0,0,0,0,7));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,0,0,1,0,0,0,0,7));
        cyc(0, 1, 0, mk(3,1,1,0,0,0,0,0,1,0,0,0,0,7));

        // sw aborted by reset during the MEM stall
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,8));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,1,0,0,0,0,8));
        cyc(0, 0, 0, mk(2,0,0,0,0,0,0,0,1,0,0,0,0,8));
        cyc(0, 0, 0, mk(3,1,1,0,0,0,0,0,1,0,0,0,0,8));
        cyc(1, 0, 0, mk(3,1,1,0,0,0,0,0,1,0,0,0,0,8));
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));

        // j retiring from a preloaded all-ones counter
        force dut.cnt = 32'hFFFF_FFFF;
        release dut.cnt;
        ins(6'b000010, 6'b000000);
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,-1));
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,-1));
        cyc(0, 0, 0, mk(1,0,0,0,1,2,0,0,0,0,0,0,0,-1));
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));

        // illegal opcode halts until reset; mem_ready/zero ignored in HALT
        ins(6'b111111, 6'b000000);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,0));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (20) cyc(0, 1, 1, mk(5,0,0,0,0,0,0,0,0,0,0,0,1,0));
        cyc(1, 0, 0, mk(5,0,0,0,0,0,0,0,0,0,0,0,1,0));
        cyc(0, 0, 0, mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));

        // illegal R-type funct
        ins(6'b000000, 6'b111111);
        cyc(0, 1, 0, mk(0,1,0,1,1,0,0,0,0,0,0,0,0,0));
        cyc(0, 0, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        cyc(0, 0, 0, mk(5,0,0,0,0,0,0,0,0,0,0,0,1,0));

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
